// File: rtl/deque_pkg.sv
`default_nettype none
// ============================================================================
// Module   : deque_pkg
// Brief    : Command and state encodings shared by the deque engine files.
// Revision : 1.0 - initial release
// ============================================================================
package deque_pkg;

    typedef enum logic [2:0] {
        NOP        = 3'd0,
        PUSH_FRONT = 3'd1,
        PUSH_BACK  = 3'd2,
        POP_FRONT  = 3'd3,
        POP_BACK   = 3'd4,
        INSERT     = 3'd5,
        DELETE_IDX = 3'd6,
        DELETE_ALL = 3'd7
    } op_e;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        SHIFT_INS = 2'd1,
        SHIFT_DEL = 2'd2,
        RESP      = 2'd3
    } state_e;

endpackage
`default_nettype wire

// File: rtl/deque_store.sv
`default_nettype none
// ============================================================================
// Module   : deque_store
// Brief    : DEPTH x DATA_W register array addressed by logical index
//            (physical = head + logical, wrapping on the power-of-two depth).
// Revision : 1.0 - initial release
// ============================================================================
module deque_store #(
    parameter  int DATA_W = 32,
    parameter  int DEPTH  = 8,
    localparam int IDX_W  = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic [IDX_W-1:0]  head,
    input  logic              we,
    input  logic [IDX_W-1:0]  wr_idx,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [IDX_W-1:0]  rd_a_idx,
    input  logic [IDX_W-1:0]  rd_b_idx,
    output logic [DATA_W-1:0] rd_a_data,
    output logic [DATA_W-1:0] rd_b_data
);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [IDX_W-1:0]  w_wr_phys;
    logic [IDX_W-1:0]  w_rd_a_phys;
    logic [IDX_W-1:0]  w_rd_b_phys;

    assign w_wr_phys   = head + wr_idx;
    assign w_rd_a_phys = head + rd_a_idx;
    assign w_rd_b_phys = head + rd_b_idx;

    // Contents need no reset: the engine never reads beyond the live count.
    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[w_wr_phys] <= wr_data;
        end
    end

    assign rd_a_data = r_mem[w_rd_a_phys];
    assign rd_b_data = r_mem[w_rd_b_phys];

endmodule
`default_nettype wire

// File: rtl/deque_engine.sv
`default_nettype none
// ============================================================================
// Module   : deque_engine
// Brief    : Double-ended queue command responder; indexed insert/delete
//            shift one element per cycle. DEQUE_PEEK_EN adds front/back views.
// Revision : 1.0 - initial release
// ============================================================================
module deque_engine
    import deque_pkg::*;
#(
    parameter  int DATA_W = 32,
    parameter  int DEPTH  = 8,
    localparam int IDX_W  = $clog2(DEPTH),
    localparam int CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  op_e               req_op,
    input  logic [IDX_W:0]    req_idx,
    input  logic [DATA_W-1:0] req_data,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic [CNT_W-1:0]  rsp_size,
    output logic              rsp_err
`ifdef DEQUE_PEEK_EN
    ,
    output logic [DATA_W-1:0] peek_front,
    output logic [DATA_W-1:0] peek_back
`endif
);

    state_e            r_state;
    logic [IDX_W-1:0]  r_head;
    logic [CNT_W-1:0]  r_count;
    logic [IDX_W-1:0]  r_j;
    logic [IDX_W-1:0]  r_idx;
    logic [DATA_W-1:0] r_data;
    logic              r_rsp_valid;
    logic [DATA_W-1:0] r_rsp_data;
    logic [CNT_W-1:0]  r_rsp_size;
    logic              r_rsp_err;

    logic              w_accept;
    logic              w_full;
    logic              w_empty;
    logic              w_err;
    logic [IDX_W-1:0]  w_cnt_lo;
    logic              w_we;
    logic [IDX_W-1:0]  w_wr_idx;
    logic [DATA_W-1:0] w_wr_data;
    logic [IDX_W-1:0]  w_rd_a_idx;
    logic [IDX_W-1:0]  w_rd_b_idx;
    logic [DATA_W-1:0] w_rd_a;
    logic [DATA_W-1:0] w_rd_b;

    assign w_accept = req_valid && (r_state == IDLE);
    assign w_full   = (r_count == CNT_W'(DEPTH));
    assign w_empty  = (r_count == '0);
    assign w_cnt_lo = r_count[IDX_W-1:0];

    always_comb begin
        w_err = 1'b0;
        case (req_op)
            PUSH_FRONT, PUSH_BACK: w_err = w_full;
            POP_FRONT, POP_BACK:   w_err = w_empty;
            INSERT:                w_err = w_full || (req_idx > r_count);
            DELETE_IDX:            w_err = (req_idx >= r_count);
            default:               w_err = 1'b0;
        endcase
    end

    // Port b normally tracks the back element; port a serves pops and shifts.
    always_comb begin
        w_we       = 1'b0;
        w_wr_idx   = w_cnt_lo;
        w_wr_data  = req_data;
        w_rd_a_idx = w_cnt_lo - IDX_W'(2);
        w_rd_b_idx = w_cnt_lo - IDX_W'(1);
        case (r_state)
            IDLE: begin
                if (req_op == POP_FRONT) begin
                    w_rd_a_idx = '0;
                    w_rd_b_idx = IDX_W'(1);
                end else if (req_op == INSERT) begin
                    w_rd_a_idx = w_cnt_lo - IDX_W'(1);
                end
                if (w_accept && !w_err) begin
                    case (req_op)
                        PUSH_FRONT: begin
                            w_we     = 1'b1;
                            w_wr_idx = '1;
                        end
                        PUSH_BACK: w_we = 1'b1;
                        INSERT: begin
                            // Shifted inserts move the back element up in the accept cycle.
                            w_we      = 1'b1;
                            w_wr_data = (req_idx == r_count) ? req_data : w_rd_a;
                        end
                        default: w_we = 1'b0;
                    endcase
                end
            end
            SHIFT_INS: begin
                w_rd_a_idx = r_j - IDX_W'(1);
                w_we       = 1'b1;
                w_wr_idx   = r_j;
                w_wr_data  = (r_j == r_idx) ? r_data : w_rd_a;
            end
            SHIFT_DEL: begin
                w_rd_a_idx = r_j + IDX_W'(1);
                w_rd_b_idx = '0;
                w_we       = 1'b1;
                w_wr_idx   = r_j;
                w_wr_data  = w_rd_a;
            end
            default: w_we = 1'b0;
        endcase
    end

    deque_store #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_store (
        .clk       (clk),
        .head      (r_head),
        .we        (w_we),
        .wr_idx    (w_wr_idx),
        .wr_data   (w_wr_data),
        .rd_a_idx  (w_rd_a_idx),
        .rd_b_idx  (w_rd_b_idx),
        .rd_a_data (w_rd_a),
        .rd_b_data (w_rd_b)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_head      <= '0;
            r_count     <= '0;
            r_j         <= '0;
            r_idx       <= '0;
            r_data      <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= '0;
            r_rsp_size  <= '0;
            r_rsp_err   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_state     <= RESP;
                        r_rsp_valid <= 1'b1;
                        r_rsp_data  <= '0;
                        r_rsp_size  <= r_count;
                        r_rsp_err   <= w_err;
                        r_idx       <= req_idx[IDX_W-1:0];
                        r_data      <= req_data;
                        if (!w_err) begin
                            case (req_op)
                                PUSH_FRONT: begin
                                    r_head     <= r_head - IDX_W'(1);
                                    r_count    <= r_count + CNT_W'(1);
                                    r_rsp_size <= r_count + CNT_W'(1);
                                end
                                PUSH_BACK: begin
                                    r_count    <= r_count + CNT_W'(1);
                                    r_rsp_size <= r_count + CNT_W'(1);
                                end
                                POP_FRONT: begin
                                    r_rsp_data <= w_rd_a;
                                    r_head     <= r_head + IDX_W'(1);
                                    r_count    <= r_count - CNT_W'(1);
                                    r_rsp_size <= r_count - CNT_W'(1);
                                end
                                POP_BACK: begin
                                    r_rsp_data <= w_rd_b;
                                    r_count    <= r_count - CNT_W'(1);
                                    r_rsp_size <= r_count - CNT_W'(1);
                                end
                                INSERT: begin
                                    if (req_idx == r_count) begin
                                        r_count    <= r_count + CNT_W'(1);
                                        r_rsp_size <= r_count + CNT_W'(1);
                                    end else begin
                                        r_j         <= w_cnt_lo - IDX_W'(1);
                                        r_state     <= SHIFT_INS;
                                        r_rsp_valid <= 1'b0;
                                    end
                                end
                                DELETE_IDX: begin
                                    if (req_idx == r_count - CNT_W'(1)) begin
                                        r_count    <= r_count - CNT_W'(1);
                                        r_rsp_size <= r_count - CNT_W'(1);
                                    end else begin
                                        r_j         <= req_idx[IDX_W-1:0];
                                        r_state     <= SHIFT_DEL;
                                        r_rsp_valid <= 1'b0;
                                    end
                                end
                                DELETE_ALL: begin
                                    r_count    <= '0;
                                    r_rsp_size <= '0;
                                end
                                default: r_rsp_size <= r_count;
                            endcase
                        end
                    end
                end
                SHIFT_INS: begin
                    if (r_j == r_idx) begin
                        r_count     <= r_count + CNT_W'(1);
                        r_rsp_size  <= r_count + CNT_W'(1);
                        r_rsp_valid <= 1'b1;
                        r_state     <= RESP;
                    end else begin
                        r_j <= r_j - IDX_W'(1);
                    end
                end
                SHIFT_DEL: begin
                    if (r_j == w_cnt_lo - IDX_W'(2)) begin
                        r_count     <= r_count - CNT_W'(1);
                        r_rsp_size  <= r_count - CNT_W'(1);
                        r_rsp_valid <= 1'b1;
                        r_state     <= RESP;
                    end else begin
                        r_j <= r_j + IDX_W'(1);
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_state     <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign req_ready = (r_state == IDLE);
    assign rsp_valid = r_rsp_valid;
    assign rsp_data  = r_rsp_data;
    assign rsp_size  = r_rsp_size;
    assign rsp_err   = r_rsp_err;

`ifdef DEQUE_PEEK_EN
    logic [DATA_W-1:0] r_peek_front;
    logic [DATA_W-1:0] r_peek_back;

    // Track the new front/back in the same edge that commits head/count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_peek_front <= '0;
            r_peek_back  <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept && !w_err) begin
                        case (req_op)
                            PUSH_FRONT: begin
                                r_peek_front <= req_data;
                                if (w_empty) r_peek_back <= req_data;
                            end
                            PUSH_BACK: begin
                                r_peek_back <= req_data;
                                if (w_empty) r_peek_front <= req_data;
                            end
                            INSERT: begin
                                if (req_idx == r_count) begin
                                    r_peek_back <= req_data;
                                    if (w_empty) r_peek_front <= req_data;
                                end
                            end
                            POP_FRONT: begin
                                r_peek_front <= (r_count == CNT_W'(1)) ? '0 : w_rd_b;
                                if (r_count == CNT_W'(1)) r_peek_back <= '0;
                            end
                            POP_BACK, DELETE_IDX: begin
                                if (req_op == POP_BACK || req_idx == r_count - CNT_W'(1)) begin
                                    r_peek_back <= (r_count == CNT_W'(1)) ? '0 : w_rd_a;
                                    if (r_count == CNT_W'(1)) r_peek_front <= '0;
                                end
                            end
                            DELETE_ALL: begin
                                r_peek_front <= '0;
                                r_peek_back  <= '0;
                            end
                            default: r_peek_front <= r_peek_front;
                        endcase
                    end
                end
                SHIFT_INS: begin
                    if (r_j == r_idx && r_idx == '0) r_peek_front <= r_data;
                end
                SHIFT_DEL: begin
                    if (r_j == w_cnt_lo - IDX_W'(2) && r_idx == '0) begin
                        r_peek_front <= (r_j == '0) ? w_rd_a : w_rd_b;
                    end
                end
                default: r_peek_front <= r_peek_front;
            endcase
        end
    end

    assign peek_front = r_peek_front;
    assign peek_back  = r_peek_back;
`endif

endmodule
`default_nettype wire

// File: tb/tb_deque_engine.sv
`default_nettype none
// ============================================================================
// Module   : tb_deque_engine
// Brief    : Directed self-checking bench for deque_engine (DEPTH=8, DATA_W=32).
// Revision : 1.0 - initial release
// ============================================================================
module tb_deque_engine;
    import deque_pkg::*;

    localparam int DATA_W = 32;
    localparam int DEPTH  = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic              req_valid;
    logic              req_ready;
    op_e               req_op;
    logic [3:0]        req_idx;
    logic [DATA_W-1:0] req_data;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_data;
    logic [3:0]        rsp_size;
    logic              rsp_err;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] got_data;
    logic [31:0] got_size;
    logic [31:0] got_err;
    int          got_lat;

    always #5 clk = ~clk;

    deque_engine #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_idx   (req_idx),
        .req_data  (req_data),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_size  (rsp_size),
        .rsp_err   (rsp_err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    // Issue one command and capture its response; rsp_ready must be high.
    task automatic do_cmd(input op_e op, input logic [3:0] idx, input logic [31:0] data);
        int k;
        k = 0;
        while (!req_ready && k < 50) begin
            @(posedge clk); #1; k++;
        end
        if (!req_ready) check("req_ready_timeout", 32'd0, 32'd1);
        @(negedge clk);
        req_valid = 1'b1;
        req_op    = op;
        req_idx   = idx;
        req_data  = data;
        @(posedge clk); #1;
        req_valid = 1'b0;
        got_lat   = 1;
        while (!rsp_valid && got_lat < 50) begin
            @(posedge clk); #1; got_lat++;
        end
        if (!rsp_valid) check("rsp_valid_timeout", 32'd0, 32'd1);
        got_data = rsp_data;
        got_size = 32'(rsp_size);
        got_err  = 32'(rsp_err);
        @(posedge clk); #1;
    endtask

    task automatic cmd_chk(input string tag, input op_e op, input logic [3:0] idx,
                           input logic [31:0] data, input logic [31:0] exp_data,
                           input logic [31:0] exp_size, input logic [31:0] exp_err);
        do_cmd(op, idx, data);
        check({tag, "_data"}, got_data, exp_data);
        check({tag, "_size"}, got_size, exp_size);
        check({tag, "_err"},  got_err,  exp_err);
    endtask

    task automatic push_n(input int n, input logic [31:0] base);
        for (int i = 0; i < n; i++) do_cmd(PUSH_BACK, 4'd0, base + 32'(i));
    endtask

    initial begin
        rst = 1'b1; req_valid = 1'b0; req_op = NOP; req_idx = '0;
        req_data = '0; rsp_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_req_ready", 32'(req_ready), 32'd1);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_size",  32'(rsp_size),  32'd0);
        check("rst_rsp_err",   32'(rsp_err),   32'd0);
        check("rst_rsp_data",  rsp_data,       32'd0);
        rst = 1'b0;

        // 1: basic push/pop at both ends
        cmd_chk("t1_pb1", PUSH_BACK,  4'd0, 32'd1, 32'd0, 32'd1, 32'd0);
        check("t1_pb1_lat", 32'(got_lat), 32'd1);
        cmd_chk("t1_pb2", PUSH_BACK,  4'd0, 32'd2, 32'd0, 32'd2, 32'd0);
        cmd_chk("t1_pf7", PUSH_FRONT, 4'd0, 32'd7, 32'd0, 32'd3, 32'd0);
        cmd_chk("t1_pb8", PUSH_BACK,  4'd0, 32'd8, 32'd0, 32'd4, 32'd0);
        cmd_chk("t1_popf", POP_FRONT, 4'd0, 32'd0, 32'd7, 32'd3, 32'd0);
        cmd_chk("t1_popb", POP_BACK,  4'd0, 32'd0, 32'd8, 32'd2, 32'd0);
        cmd_chk("t1_nop",  NOP,       4'd0, 32'd0, 32'd0, 32'd2, 32'd0);
        cmd_chk("t1_clr",  DELETE_ALL,4'd0, 32'd0, 32'd0, 32'd0, 32'd0);

        // 2: wrap-around and full
        push_n(8, 32'd10);
        check("t2_size8", got_size, 32'd8);
        cmd_chk("t2_popf0", POP_FRONT, 4'd0, 32'd0, 32'd10, 32'd7, 32'd0);
        cmd_chk("t2_popf1", POP_FRONT, 4'd0, 32'd0, 32'd11, 32'd6, 32'd0);
        cmd_chk("t2_popf2", POP_FRONT, 4'd0, 32'd0, 32'd12, 32'd5, 32'd0);
        push_n(3, 32'd20);
        check("t2_refill_size", got_size, 32'd8);
        check("t2_refill_err",  got_err,  32'd0);
        cmd_chk("t2_full_pb", PUSH_BACK,  4'd0, 32'd99, 32'd0, 32'd8, 32'd1);
        cmd_chk("t2_full_pf", PUSH_FRONT, 4'd0, 32'd99, 32'd0, 32'd8, 32'd1);
        cmd_chk("t2_full_ins", INSERT,    4'd2, 32'd99, 32'd0, 32'd8, 32'd1);
        cmd_chk("t2_popb", POP_BACK,  4'd0, 32'd0, 32'd22, 32'd7, 32'd0);
        cmd_chk("t2_popf", POP_FRONT, 4'd0, 32'd0, 32'd13, 32'd6, 32'd0);
        cmd_chk("t2_clr",  DELETE_ALL,4'd0, 32'd0, 32'd0, 32'd0, 32'd0);

        // 3: indexed insert
        push_n(3, 32'd100);
        cmd_chk("t3_ins1", INSERT, 4'd1, 32'd999, 32'd0, 32'd4, 32'd0);
        check("t3_ins1_lat", 32'(got_lat), 32'd3);
        cmd_chk("t3_pop0", POP_FRONT, 4'd0, 32'd0, 32'd100, 32'd3, 32'd0);
        cmd_chk("t3_pop1", POP_FRONT, 4'd0, 32'd0, 32'd999, 32'd2, 32'd0);
        cmd_chk("t3_pop2", POP_FRONT, 4'd0, 32'd0, 32'd101, 32'd1, 32'd0);
        cmd_chk("t3_pop3", POP_FRONT, 4'd0, 32'd0, 32'd102, 32'd0, 32'd0);
        push_n(3, 32'd100);
        cmd_chk("t3_ins_bad", INSERT, 4'd4, 32'd5, 32'd0, 32'd3, 32'd0 + 32'd1);
        check("t3_ins_bad_lat", 32'(got_lat), 32'd1);
        cmd_chk("t3_ins_end", INSERT, 4'd3, 32'd555, 32'd0, 32'd4, 32'd0);
        check("t3_ins_end_lat", 32'(got_lat), 32'd1);
        cmd_chk("t3_ins0", INSERT, 4'd0, 32'd777, 32'd0, 32'd5, 32'd0);
        check("t3_ins0_lat", 32'(got_lat), 32'd5);
        cmd_chk("t3_q0", POP_FRONT, 4'd0, 32'd0, 32'd777, 32'd4, 32'd0);
        cmd_chk("t3_q1", POP_FRONT, 4'd0, 32'd0, 32'd100, 32'd3, 32'd0);
        cmd_chk("t3_q4", POP_BACK,  4'd0, 32'd0, 32'd555, 32'd2, 32'd0);
        cmd_chk("t3_q3", POP_BACK,  4'd0, 32'd0, 32'd102, 32'd1, 32'd0);
        cmd_chk("t3_q2", POP_BACK,  4'd0, 32'd0, 32'd101, 32'd0, 32'd0);

        // 4: indexed delete
        push_n(5, 32'd300);
        cmd_chk("t4_del2", DELETE_IDX, 4'd2, 32'd0, 32'd0, 32'd4, 32'd0);
        check("t4_del2_lat", 32'(got_lat), 32'd3);
        cmd_chk("t4_pop0", POP_FRONT, 4'd0, 32'd0, 32'd300, 32'd3, 32'd0);
        cmd_chk("t4_pop1", POP_FRONT, 4'd0, 32'd0, 32'd301, 32'd2, 32'd0);
        cmd_chk("t4_pop2", POP_FRONT, 4'd0, 32'd0, 32'd303, 32'd1, 32'd0);
        cmd_chk("t4_pop3", POP_FRONT, 4'd0, 32'd0, 32'd304, 32'd0, 32'd0);
        push_n(4, 32'd400);
        cmd_chk("t4_del_bad", DELETE_IDX, 4'd5, 32'd0, 32'd0, 32'd4, 32'd1);
        cmd_chk("t4_del_idx4", DELETE_IDX, 4'd4, 32'd0, 32'd0, 32'd4, 32'd1);
        cmd_chk("t4_del_last", DELETE_IDX, 4'd3, 32'd0, 32'd0, 32'd3, 32'd0);
        check("t4_del_last_lat", 32'(got_lat), 32'd1);
        cmd_chk("t4_del0", DELETE_IDX, 4'd0, 32'd0, 32'd0, 32'd2, 32'd0);
        cmd_chk("t4_r0", POP_FRONT, 4'd0, 32'd0, 32'd401, 32'd1, 32'd0);
        cmd_chk("t4_r1", POP_FRONT, 4'd0, 32'd0, 32'd402, 32'd0, 32'd0);

        // 5: delete-all and empty errors
        push_n(4, 32'd500);
        cmd_chk("t5_clr", DELETE_ALL, 4'd0, 32'd0, 32'd0, 32'd0, 32'd0);
        cmd_chk("t5_pop_empty",  POP_FRONT, 4'd0, 32'd0, 32'd0, 32'd0, 32'd1);
        cmd_chk("t5_popb_empty", POP_BACK,  4'd0, 32'd0, 32'd0, 32'd0, 32'd1);
        cmd_chk("t5_del_empty", DELETE_IDX, 4'd0, 32'd0, 32'd0, 32'd0, 32'd1);
        cmd_chk("t5_clr_empty", DELETE_ALL, 4'd0, 32'd0, 32'd0, 32'd0, 32'd0);

        // 6a: response held while rsp_ready is low
        do_cmd(PUSH_BACK, 4'd0, 32'd5);
        rsp_ready = 1'b0;
        @(negedge clk);
        req_valid = 1'b1; req_op = POP_FRONT;
        @(posedge clk); #1;
        req_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("t6_hold_valid", 32'(rsp_valid), 32'd1);
            check("t6_hold_ready", 32'(req_ready), 32'd0);
            check("t6_hold_data",  rsp_data,       32'd5);
            check("t6_hold_size",  32'(rsp_size),  32'd0);
            @(posedge clk); #1;
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        check("t6_release_valid", 32'(rsp_valid), 32'd0);
        check("t6_release_ready", 32'(req_ready), 32'd1);

        // 6b: asynchronous reset in the middle of an insert shift
        push_n(5, 32'd600);
        @(negedge clk);
        req_valid = 1'b1; req_op = INSERT; req_idx = 4'd0; req_data = 32'd42;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        check("t6_mid_shift_ready", 32'(req_ready), 32'd0);
        #2 rst = 1'b1;
        #1;
        check("t6_arst_ready", 32'(req_ready), 32'd1);
        check("t6_arst_valid", 32'(rsp_valid), 32'd0);
        check("t6_arst_size",  32'(rsp_size),  32'd0);
        check("t6_arst_err",   32'(rsp_err),   32'd0);
        check("t6_arst_data",  rsp_data,       32'd0);
        @(negedge clk);
        rst = 1'b0;
        cmd_chk("t6_post_pop", POP_FRONT, 4'd0, 32'd0, 32'd0, 32'd0, 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
